codeword_bank_sel: RTL and testbench
====================================

# codeword_bank_sel

Parametrised, double-buffered codeword store and per-beam selector for the PUSCH dimension-reduction path. A load FSM streams a full even/odd codebook from an external ROM into a shadow bank while the active bank keeps serving beams. On a symbol-clear boundary the banks swap. Per beam it outputs even/odd codewords selected either by symbol phase (first symbol) or by the sorted beam index (RBG load).

## Interface
Parameters:
- ANTS, 32, antennas per codeword
- BEAM, 16, output beams
- WIDTH, 32, bits per antenna coefficient
- PHASES, 4, symbol phases; power of 2; BEAM*PHASES <= DEPTH
- DEPTH, 64, codewords per bank
- IDXW, $clog2(DEPTH), index width
- ROM_LAT, 2, ROM read latency in cycles (>=1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - i_clk  in  1  clock
  - i_reset  in  1  asynchronous, active-high reset
- Load control:
  - i_load_start  in  1  pulse; start a codebook load into the shadow bank
  - o_rom_rden  out  1  ROM read enable
  - o_rom_addr  out  IDXW  ROM address
  - i_rom_even  in  WIDTH*ANTS  even codeword, valid ROM_LAT cycles after rden
  - i_rom_odd  in  WIDTH*ANTS  odd codeword, same timing
  - o_load_busy  out  1  FSM not IDLE
  - o_load_done  out  1  one-cycle pulse at end of load
- Selection:
  - i_beam_idx  in  [BEAM][IDXW]  sorted beam index per beam
  - i_symb_idx  in  8  symbol index; low log2(PHASES) bits are used
  - i_symb_clr  in  1  symbol clear / bank-swap point
  - i_symb_1st  in  1  first symbol of slot
  - i_rbg_load  in  1  load index-selected codewords
- Outputs:
  - o_cw_even  out  [BEAM][WIDTH*ANTS]  even codeword per beam
  - o_cw_odd  out  [BEAM][WIDTH*ANTS]  odd codeword per beam
  - o_tvalid  out  1  active bank holds a complete codebook
  - o_idx_err  out  1  sticky; some i_beam_idx >= DEPTH was used

## Operation
- Reset values: all outputs 0, FSM IDLE, both bank-valid flags 0, swap-pending flag 0, active bank = 0. Bank storage is not reset.
- Load FSM states and transitions:
  - IDLE→READ on i_load_start. A start pulse is ignored when not IDLE.
  - READ: rden=1 with addr 0..DEPTH-1, one per cycle; after addr DEPTH-1 go to DRAIN.
  - DRAIN: wait ROM_LAT cycles, then DONE.
  - DONE: o_load_done=1 for one cycle, then IDLE.
- Write-back: rden and addr are delayed ROM_LAT cycles; when the delayed rden is 1, both shadow bank entries at the delayed addr are written.
- Accepting a start clears the shadow valid flag and swap-pending.
- At DONE the shadow becomes valid.
  - If the active bank is not valid, the banks swap immediately (next cycle).
  - Otherwise swap-pending is set.
- Swap: on i_symb_clr with swap-pending already set, toggle the active bank and clear pending.
- o_tvalid is 1 iff the active bank is valid.
- Selection, per beam i, with priority order:
  1. i_symb_clr → cw[i] = active[i].
  2. Else if the registered symb_1st is set → cw[i] = active[i + BEAM*p], where p is the registered i_symb_idx mod PHASES.
  3. Else if i_rbg_load → cw[i] = sel[i].
  4. Else hold.
- sel[i] is registered every cycle from active[i_beam_idx[i]].
  - An index >= DEPTH gives sel[i]=0 and sets o_idx_err.
  - o_idx_err clears only on reset.
- Selection always reads the active bank; the loader never writes it.

## Timing
- Start accepted at cycle t. Addr k is issued at t+1+k. The last write is at t+DEPTH+ROM_LAT. o_load_done is at t+DEPTH+ROM_LAT+1.
- Immediate activation: o_tvalid rises the cycle after o_load_done.
- i_symb_clr at cycle c: outputs update at c+1. A pending swap takes effect with this clear, so it reads the new bank.
- i_symb_1st/i_symb_idx at cycle c: outputs update at c+2.
- i_beam_idx must be stable from cycle c-1. i_rbg_load at c → outputs update at c+1.
- o_load_done and i_symb_clr in the same cycle: pending is not yet set, so the swap waits for the next clear.
- Reset mid-load: FSM → IDLE, rden drops asynchronously, and no further write occurs.

## Test plan
- Reset, ROM word(a)=a replicated, pulse start → rden high 64 cycles with addr 0..63; o_load_done 67 cycles after start; o_tvalid=1 next cycle.
- Load, then symb_1st=1 with symb_idx=2 → two cycles later cw_even[5]=word 37.
- Second load with ROM word(a)=a+100 while active; before clear, cw unchanged. Then i_symb_clr → cw_even[3]=103, and active toggles.
- i_beam_idx[0]=63, i_beam_idx[1]=70 for 1 cycle, then rbg_load → cw[0]=word 63, cw[1]=0, o_idx_err=1 and stays 1.
- o_load_done coincident with i_symb_clr → no swap; the next clear swaps.
- Assert i_reset at READ addr 20 → all outputs 0 immediately; a subsequent start reloads from addr 0.

Source files
------------

// File: rtl/codeword_bank_sel.sv
// codeword_bank_sel: double-buffered even/odd codebook store with per-beam codeword selection.
// Ports:
//   i_clk, i_reset             clock, asynchronous active-high reset
//   i_load_start               pulse; load the shadow bank from the ROM (ignored unless idle)
//   o_rom_rden, o_rom_addr     ROM read strobe and address (one address per cycle)
//   i_rom_even, i_rom_odd      ROM codewords, valid ROM_LAT cycles after o_rom_rden
//   o_load_busy, o_load_done   loader not idle / one-cycle end-of-load pulse
//   i_beam_idx                 sorted codebook index per beam
//   i_symb_idx, i_symb_clr     symbol index (low bits = phase), symbol clear / bank-swap point
//   i_symb_1st, i_rbg_load     first-symbol phase selection, index-based selection
//   o_cw_even, o_cw_odd        selected codewords per beam
//   o_tvalid                   active bank holds a complete codebook
//   o_idx_err                  sticky out-of-range beam index flag
module codeword_bank_sel #(
    parameter int ANTS    = 32,
    parameter int BEAM    = 16,
    parameter int WIDTH   = 32,
    parameter int PHASES  = 4,
    parameter int DEPTH   = 64,
    parameter int IDXW    = $clog2(DEPTH),
    parameter int ROM_LAT = 2
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_load_start,
    output logic                                o_rom_rden,
    output logic [IDXW-1:0]                     o_rom_addr,
    input  logic [WIDTH*ANTS-1:0]               i_rom_even,
    input  logic [WIDTH*ANTS-1:0]               i_rom_odd,
    output logic                                o_load_busy,
    output logic                                o_load_done,
    input  logic [BEAM-1:0][IDXW-1:0]           i_beam_idx,
    input  logic [7:0]                          i_symb_idx,
    input  logic                                i_symb_clr,
    input  logic                                i_symb_1st,
    input  logic                                i_rbg_load,
    output logic [BEAM-1:0][WIDTH*ANTS-1:0]     o_cw_even,
    output logic [BEAM-1:0][WIDTH*ANTS-1:0]     o_cw_odd,
    output logic                                o_tvalid,
    output logic                                o_idx_err
);
    localparam int CW   = WIDTH * ANTS;
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = $clog2(PHASES);
    localparam int CNTW = $clog2(ROM_LAT + 1);
    localparam logic [IDXW:0] DEPTH_W = (IDXW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state_q;
    logic [IDXW-1:0] addr_q;
    logic [CNTW-1:0] cnt_q;
    logic [1:0]      vld_q;
    logic            pend_q;
    logic            act_q;
    logic            accept;

    assign accept      = (state_q == IDLE) && i_load_start;
    assign o_rom_rden  = (state_q == READ);
    assign o_rom_addr  = addr_q;
    assign o_load_busy = (state_q != IDLE);
    assign o_load_done = (state_q == DONE);
    assign o_tvalid    = vld_q[act_q];

    // Loader FSM plus bank bookkeeping; the shadow bank is always ~act_q.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            pend_q  <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_load_start) begin
                    state_q        <= READ;
                    vld_q[~act_q]  <= 1'b0;
                    pend_q         <= 1'b0;
                end
                READ: begin
                    addr_q <= addr_q + 1'b1;
                    if (addr_q == IDXW'(DEPTH - 1)) begin
                        state_q <= DRAIN;
                        addr_q  <= '0;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNTW'(ROM_LAT - 1)) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    vld_q[~act_q] <= 1'b1;
                    // With nothing valid to serve, go live at once; otherwise wait for a symbol clear.
                    if (!vld_q[act_q]) act_q <= ~act_q;
                    else pend_q <= 1'b1;
                end
            endcase
            // A newly accepted load owns the shadow bank, so it wins over a coincident swap.
            if (i_symb_clr && pend_q && !accept) begin
                act_q  <= ~act_q;
                pend_q <= 1'b0;
            end
        end
    end

    // Read strobe/address delayed to line up with the ROM data.
    logic [ROM_LAT-1:0] dv_q;
    logic [IDXW-1:0]    da_q [ROM_LAT];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dv_q <= '0;
            for (int k = 0; k < ROM_LAT; k++) da_q[k] <= '0;
        end else begin
            dv_q[0] <= o_rom_rden;
            da_q[0] <= addr_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                dv_q[k] <= dv_q[k-1];
                da_q[k] <= da_q[k-1];
            end
        end
    end

    logic [CW-1:0] even_q [2][DEPTH];
    logic [CW-1:0] odd_q  [2][DEPTH];
    logic [AW-1:0] wr_addr;

    assign wr_addr = da_q[ROM_LAT-1][AW-1:0];

    always_ff @(posedge i_clk) begin
        if (dv_q[ROM_LAT-1]) begin
            even_q[~act_q][wr_addr] <= i_rom_even;
            odd_q[~act_q][wr_addr]  <= i_rom_odd;
        end
    end

    logic          sym1_q;
    logic [PW-1:0] ph_q;
    logic          err_q;
    logic          rd_bank;
    logic [BEAM-1:0] oob;
    logic          unused_bits;

    // A clear that completes a pending swap already reads the incoming bank.
    assign rd_bank     = act_q ^ (i_symb_clr & pend_q);
    assign o_idx_err   = err_q;
    assign unused_bits = ^{i_symb_idx, da_q[ROM_LAT-1]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sym1_q <= 1'b0;
            ph_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            sym1_q <= i_symb_1st;
            ph_q   <= i_symb_idx[PW-1:0];
            err_q  <= err_q | (|oob);
        end
    end

    for (genvar g = 0; g < BEAM; g++) begin : g_beam
        logic [CW-1:0] sel_e_q, sel_o_q, cw_e_q, cw_o_q;
        logic [AW-1:0] ph_addr;
        logic [AW-1:0] bi;
        assign oob[g]       = {1'b0, i_beam_idx[g]} >= DEPTH_W;
        assign bi           = i_beam_idx[g][AW-1:0];
        assign ph_addr      = AW'(g + BEAM * int'(ph_q));
        assign o_cw_even[g] = cw_e_q;
        assign o_cw_odd[g]  = cw_o_q;
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                sel_e_q <= '0;
                sel_o_q <= '0;
                cw_e_q  <= '0;
                cw_o_q  <= '0;
            end else begin
                sel_e_q <= oob[g] ? '0 : even_q[act_q][bi];
                sel_o_q <= oob[g] ? '0 : odd_q[act_q][bi];
                if (i_symb_clr) begin
                    cw_e_q <= even_q[rd_bank][AW'(g)];
                    cw_o_q <= odd_q[rd_bank][AW'(g)];
                end else if (sym1_q) begin
                    cw_e_q <= even_q[act_q][ph_addr];
                    cw_o_q <= odd_q[act_q][ph_addr];
                end else if (i_rbg_load) begin
                    cw_e_q <= sel_e_q;
                    cw_o_q <= sel_o_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_codeword_bank_sel.sv
// tb_codeword_bank_sel: scoreboard bench for codeword_bank_sel with a latency-accurate ROM model.
module tb_codeword_bank_sel;
    localparam int ANTS = 4, BEAM = 16, WIDTH = 16, PHASES = 4, DEPTH = 64, IDXW = 7, ROM_LAT = 2;
    localparam int CW = WIDTH * ANTS;
    localparam int K_EVEN = 0, K_ODD = 1, K_TVALID = 2, K_ERR = 3, K_DONE = 4, K_RDEN = 5, K_ADDR = 6, K_BUSY = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_start = 1'b0;
    logic rden, busy, load_done, tvalid, idx_err;
    logic [IDXW-1:0] rom_addr;
    logic [CW-1:0] rom_even, rom_odd;
    logic [BEAM-1:0][IDXW-1:0] beam_idx = '0;
    logic [7:0] symb_idx = '0;
    logic symb_clr = 1'b0, symb_1st = 1'b0, rbg_load = 1'b0;
    logic [BEAM-1:0][CW-1:0] cw_even, cw_odd;

    codeword_bank_sel #(
        .ANTS(ANTS), .BEAM(BEAM), .WIDTH(WIDTH), .PHASES(PHASES),
        .DEPTH(DEPTH), .IDXW(IDXW), .ROM_LAT(ROM_LAT)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_load_start(load_start),
        .o_rom_rden(rden), .o_rom_addr(rom_addr),
        .i_rom_even(rom_even), .i_rom_odd(rom_odd),
        .o_load_busy(busy), .o_load_done(load_done),
        .i_beam_idx(beam_idx), .i_symb_idx(symb_idx), .i_symb_clr(symb_clr),
        .i_symb_1st(symb_1st), .i_rbg_load(rbg_load),
        .o_cw_even(cw_even), .o_cw_odd(cw_odd), .o_tvalid(tvalid), .o_idx_err(idx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [CW-1:0] word(int v);
        logic [CW-1:0] w;
        for (int k = 0; k < ANTS; k++) w[k*WIDTH +: WIDTH] = WIDTH'(v);
        return w;
    endfunction

    // ROM: data for an address appears ROM_LAT(=2) cycles after it is presented.
    int off = 0;
    logic [IDXW-1:0] p1, p2;
    always @(posedge clk) begin
        p1 <= rom_addr;
        p2 <= p1;
    end
    assign rom_even = word(int'(p2) + off);
    assign rom_odd  = word(int'(p2) + off + 500);

    typedef struct {
        int cyc;
        int kind;
        int beam;
        logic [CW-1:0] exp;
        string name;
    } chk_t;
    chk_t q[$];
    int checks = 0, errors = 0;

    task automatic expect_at(string name, int dt, int kind, int beam, logic [CW-1:0] exp);
        chk_t c;
        c.cyc = cyc + dt; c.kind = kind; c.beam = beam; c.exp = exp; c.name = name;
        q.push_back(c);
    endtask

    function automatic logic [CW-1:0] actual(int kind, int beam);
        case (kind)
            K_EVEN:   return cw_even[beam];
            K_ODD:    return cw_odd[beam];
            K_TVALID: return CW'(tvalid);
            K_ERR:    return CW'(idx_err);
            K_DONE:   return CW'(load_done);
            K_RDEN:   return CW'(rden);
            K_ADDR:   return CW'(rom_addr);
            default:  return CW'(busy);
        endcase
    endfunction

    // Monitor: compare every scheduled expectation in the cycle it falls due.
    always @(negedge clk) begin
        int i;
        logic [CW-1:0] a;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc == cyc) begin
                a = actual(q[i].kind, q[i].beam);
                checks++;
                if (a !== q[i].exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", q[i].name, cyc, a, q[i].exp);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s not sampled at cyc=%0d", q[i].name, q[i].cyc);
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int target);
        while (cyc < target) step();
    endtask

    int t;

    initial begin
        step(); step();
        expect_at("rst_tvalid", 0, K_TVALID, 0, '0);
        expect_at("rst_done", 0, K_DONE, 0, '0);
        expect_at("rst_rden", 0, K_RDEN, 0, '0);
        expect_at("rst_busy", 0, K_BUSY, 0, '0);
        expect_at("rst_cw_even0", 0, K_EVEN, 0, '0);
        expect_at("rst_err", 0, K_ERR, 0, '0);
        step();
        rst = 1'b0;
        step();

        // First load into an empty store: activates immediately.
        t = cyc;
        load_start = 1'b1;
        expect_at("ld1_rden_first", 1, K_RDEN, 0, CW'(1));
        expect_at("ld1_addr_first", 1, K_ADDR, 0, CW'(0));
        expect_at("ld1_addr_last", 64, K_ADDR, 0, CW'(63));
        expect_at("ld1_rden_last", 64, K_RDEN, 0, CW'(1));
        expect_at("ld1_rden_off", 65, K_RDEN, 0, CW'(0));
        expect_at("ld1_done_early", 66, K_DONE, 0, CW'(0));
        expect_at("ld1_done", 67, K_DONE, 0, CW'(1));
        expect_at("ld1_tvalid_pre", 67, K_TVALID, 0, CW'(0));
        expect_at("ld1_tvalid", 68, K_TVALID, 0, CW'(1));
        step();
        load_start = 1'b0;
        wait_until(t + 70);

        // First-symbol phase selection: beam 5, phase 2 -> entry 37.
        symb_1st = 1'b1;
        symb_idx = 8'd2;
        expect_at("ph_cw5_before", 1, K_EVEN, 5, '0);
        expect_at("ph_cw_even5", 2, K_EVEN, 5, word(37));
        expect_at("ph_cw_odd5", 2, K_ODD, 5, word(537));
        expect_at("ph_cw_even0", 2, K_EVEN, 0, word(32));
        expect_at("ph_hold", 4, K_EVEN, 5, word(37));
        step();
        symb_1st = 1'b0;
        symb_idx = 8'd0;
        step();

        // Second load while active: stays in shadow until a symbol clear.
        off = 100;
        step();
        t = cyc;
        load_start = 1'b1;
        expect_at("ld2_done", 67, K_DONE, 0, CW'(1));
        step();
        load_start = 1'b0;
        wait_until(t + 70);
        expect_at("ld2_cw_unchanged", 0, K_EVEN, 5, word(37));
        expect_at("ld2_tvalid", 0, K_TVALID, 0, CW'(1));
        symb_clr = 1'b1;
        expect_at("swap_cw_even3", 1, K_EVEN, 3, word(103));
        expect_at("swap_cw_odd3", 1, K_ODD, 3, word(603));
        step();
        symb_clr = 1'b0;
        symb_1st = 1'b1;
        symb_idx = 8'd1;
        expect_at("swap_phase_new_bank", 2, K_EVEN, 2, word(118));
        step();
        symb_1st = 1'b0;
        symb_idx = 8'd0;
        step(); step();

        // Index selection with one out-of-range index.
        beam_idx[0] = 7'd63;
        beam_idx[1] = 7'd70;
        expect_at("idx_err_before", 0, K_ERR, 0, '0);
        expect_at("idx_err_set", 1, K_ERR, 0, CW'(1));
        step();
        beam_idx = '0;
        rbg_load = 1'b1;
        expect_at("rbg_cw_even0", 1, K_EVEN, 0, word(163));
        expect_at("rbg_cw_even1_oob", 1, K_EVEN, 1, '0);
        expect_at("rbg_cw_odd1_oob", 1, K_ODD, 1, '0);
        expect_at("rbg_cw_even2", 1, K_EVEN, 2, word(100));
        expect_at("idx_err_sticky", 4, K_ERR, 0, CW'(1));
        step();
        rbg_load = 1'b0;
        step(); step(); step();

        // Load completion coincident with a clear: swap deferred to the next clear.
        off = 200;
        step();
        t = cyc;
        load_start = 1'b1;
        expect_at("ld3_done", 67, K_DONE, 0, CW'(1));
        step();
        load_start = 1'b0;
        wait_until(t + 67);
        symb_clr = 1'b1;
        expect_at("coinc_no_swap", 1, K_EVEN, 3, word(103));
        step();
        symb_clr = 1'b0;
        step(); step();
        symb_clr = 1'b1;
        expect_at("coinc_next_swap", 1, K_EVEN, 3, word(203));
        expect_at("coinc_tvalid", 1, K_TVALID, 0, CW'(1));
        step();
        symb_clr = 1'b0;
        step();

        // Reset in the middle of a load.
        off = 300;
        step();
        t = cyc;
        load_start = 1'b1;
        expect_at("ld4_addr19", 20, K_ADDR, 0, CW'(19));
        step();
        load_start = 1'b0;
        wait_until(t + 21);
        rst = 1'b1;
        expect_at("mid_rst_rden", 0, K_RDEN, 0, '0);
        expect_at("mid_rst_addr", 0, K_ADDR, 0, '0);
        expect_at("mid_rst_busy", 0, K_BUSY, 0, '0);
        expect_at("mid_rst_tvalid", 0, K_TVALID, 0, '0);
        expect_at("mid_rst_cw_even3", 0, K_EVEN, 3, '0);
        expect_at("mid_rst_cw_odd3", 0, K_ODD, 3, '0);
        expect_at("mid_rst_err", 0, K_ERR, 0, '0);
        step(); step();
        rst = 1'b0;
        off = 400;
        step();
        t = cyc;
        load_start = 1'b1;
        expect_at("ld5_rden", 1, K_RDEN, 0, CW'(1));
        expect_at("ld5_addr0", 1, K_ADDR, 0, CW'(0));
        expect_at("ld5_addr1", 2, K_ADDR, 0, CW'(1));
        expect_at("ld5_done", 67, K_DONE, 0, CW'(1));
        expect_at("ld5_done_clear", 68, K_DONE, 0, CW'(0));
        expect_at("ld5_busy_clear", 68, K_BUSY, 0, CW'(0));
        expect_at("ld5_tvalid_pre", 67, K_TVALID, 0, CW'(0));
        expect_at("ld5_tvalid", 68, K_TVALID, 0, CW'(1));
        step();
        load_start = 1'b0;
        wait_until(t + 10);
        load_start = 1'b1;
        expect_at("ld5_busy_ignore", 1, K_BUSY, 0, CW'(1));
        step();
        load_start = 1'b0;
        wait_until(t + 70);
        symb_clr = 1'b1;
        expect_at("ld5_cw_even3", 1, K_EVEN, 3, word(403));
        expect_at("ld5_cw_odd3", 1, K_ODD, 3, word(903));
        step();
        symb_clr = 1'b0;

        for (int n = 0; n < 300 && q.size() > 0; n++) step();
        if (q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
